// File: rtl/ifu_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifu_rd_ctrl
// Description : Instruction fetch read controller. Turns one-cycle fetch read
//               commands into request/response transactions on the
//               instruction bus and returns the word plus alignment/bus errors.
//               Optional last-word buffer enabled by macro IFU_LAST_HIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_rd_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd_cmd,
  output logic [DATA_WIDTH-1:0] o_instr_dat,
  output logic                  o_busy,
  output logic                  o_err_align,
  output logic                  o_err_bus,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic                  o_bus_req,
  input  logic                  i_bus_ack,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata,
  input  logic                  i_bus_rdy,
  input  logic                  i_bus_err
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_dat_q, instr_dat_d;
  logic                  err_align_q, err_align_d;
  logic                  err_bus_q, err_bus_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;

  logic w_aligned;
  logic w_hit;
  logic w_accept;
  logic w_misalign_cmd;
  logic w_resp_done;

  assign w_aligned      = (i_addr[1:0] == 2'b00);
  assign w_accept       = (state_q == c_IDLE) & i_rd_cmd & w_aligned & ~w_hit;
  assign w_misalign_cmd = (state_q == c_IDLE) & i_rd_cmd & ~w_aligned;
  assign w_resp_done    = (state_q == c_RESP) & i_bus_rdy;

`ifdef IFU_LAST_HIT_EN
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  last_valid_q, last_valid_d;

  // A flush in the same cycle as a would-be hit forces a miss.
  assign w_hit = i_rd_cmd & w_aligned & last_valid_q & ~i_flush &
                 (i_addr == last_addr_q);

  // Track the last successfully fetched word; flush beats a same-cycle fill.
  always_comb begin
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
    if (w_resp_done) begin
      if (i_bus_err) begin
        last_valid_d = 1'b0;
      end else begin
        last_valid_d = 1'b1;
        last_addr_d  = bus_addr_q;
      end
    end
    if (i_flush) begin
      last_valid_d = 1'b0;
    end
  end

  // Last-word buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  logic w_unused_flush;

  // Without the buffer every aligned command misses and flush has no effect.
  assign w_hit          = 1'b0;
  assign w_unused_flush = i_flush;
`endif

  // State register; reset drops back to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; commands outside IDLE and acks outside REQ are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_accept)  state_d = c_REQ;
      c_REQ:   if (i_bus_ack) state_d = c_RESP;
      c_RESP:  if (i_bus_rdy) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // FSM outputs; busy covers the command cycle itself so fetch stalls at once.
  always_comb begin
    o_bus_req = (state_q == c_REQ);
    o_busy    = (state_q != c_IDLE) | (i_rd_cmd & w_aligned & ~w_hit);
  end

  // Result and bus-address updates; everything holds unless a command or response lands.
  always_comb begin
    instr_dat_d = instr_dat_q;
    err_align_d = err_align_q;
    err_bus_d   = err_bus_q;
    bus_addr_d  = bus_addr_q;
    if (w_misalign_cmd) begin
      instr_dat_d = '0;
      err_align_d = 1'b1;
      err_bus_d   = 1'b0;
    end else if (w_accept) begin
      bus_addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
      err_align_d = 1'b0;
      err_bus_d   = 1'b0;
    end else if (w_resp_done) begin
      if (i_bus_err) begin
        instr_dat_d = '0;
        err_bus_d   = 1'b1;
      end else begin
        instr_dat_d = i_bus_rdata;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_dat_q <= '0;
      err_align_q <= 1'b0;
      err_bus_q   <= 1'b0;
      bus_addr_q  <= '0;
    end else begin
      instr_dat_q <= instr_dat_d;
      err_align_q <= err_align_d;
      err_bus_q   <= err_bus_d;
      bus_addr_q  <= bus_addr_d;
    end
  end

  assign o_instr_dat = instr_dat_q;
  assign o_err_align = err_align_q;
  assign o_err_bus   = err_bus_q;
  assign o_bus_addr  = bus_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_rd_ctrl
// Description : Directed self-checking bench for ifu_rd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_rd_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_rd_cmd;
  logic [31:0] o_instr_dat;
  logic        o_busy;
  logic        o_err_align;
  logic        o_err_bus;
  logic        i_flush;
  logic [31:0] o_bus_addr;
  logic        o_bus_req;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;
  logic        i_bus_rdy;
  logic        i_bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  ifu_rd_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_addr      (i_addr),
    .i_rd_cmd    (i_rd_cmd),
    .o_instr_dat (o_instr_dat),
    .o_busy      (o_busy),
    .o_err_align (o_err_align),
    .o_err_bus   (o_err_bus),
    .i_flush     (i_flush),
    .o_bus_addr  (o_bus_addr),
    .o_bus_req   (o_bus_req),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata),
    .i_bus_rdy   (i_bus_rdy),
    .i_bus_err   (i_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full aligned transaction: ack after ack_wait extra REQ cycles,
  // rdy after rdy_wait extra RESP cycles. Inputs change at negedge.
  task automatic bus_read(input string nm, input logic [31:0] addr,
                          input int ack_wait, input int rdy_wait,
                          input logic [31:0] data, input logic err);
    logic [31:0] exp_dat;
    exp_dat = err ? 32'h0 : data;
    @(negedge clk);
    i_addr = addr; i_rd_cmd = 1'b1;
    #1;
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL %s cmd_busy: got %0b want 1", nm, o_busy); end
    @(negedge clk);
    i_rd_cmd = 1'b0;
    #1;
    n_checks++;
    if (o_err_align !== 1'b0 || o_err_bus !== 1'b0) begin
      n_fail++; $display("FAIL %s err_clear: got align=%0b bus=%0b want 0 0", nm, o_err_align, o_err_bus);
    end
    for (int k = 0; k <= ack_wait; k++) begin
      n_checks++;
      if (o_bus_req !== 1'b1 || o_busy !== 1'b1 || o_bus_addr !== addr) begin
        n_fail++;
        $display("FAIL %s req_phase[%0d]: got req=%0b busy=%0b addr=%h want 1 1 %h",
                 nm, k, o_bus_req, o_busy, o_bus_addr, addr);
      end
      if (k == ack_wait) i_bus_ack = 1'b1;
      @(negedge clk);
      #1;
    end
    i_bus_ack = 1'b0;
    for (int k = 0; k <= rdy_wait; k++) begin
      n_checks++;
      if (o_bus_req !== 1'b0 || o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s resp_phase[%0d]: got req=%0b busy=%0b want 0 1", nm, k, o_bus_req, o_busy);
      end
      if (k == rdy_wait) begin
        i_bus_rdy = 1'b1; i_bus_rdata = data; i_bus_err = err;
      end
      @(negedge clk);
      #1;
    end
    i_bus_rdy = 1'b0; i_bus_err = 1'b0; i_bus_rdata = 32'hA5A5_A5A5;
    n_checks++;
    if (o_busy !== 1'b0 || o_instr_dat !== exp_dat || o_err_bus !== err || o_err_align !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: got busy=%0b dat=%h ebus=%0b ealign=%0b want 0 %h %0b 0",
               nm, o_busy, o_instr_dat, o_err_bus, o_err_align, exp_dat, err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_addr = '0; i_rd_cmd = 1'b0; i_flush = 1'b0;
    i_bus_ack = 1'b0; i_bus_rdata = '0; i_bus_rdy = 1'b0; i_bus_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_bus_req !== 1'b0 || o_instr_dat !== 32'h0 ||
        o_err_align !== 1'b0 || o_err_bus !== 1'b0 || o_bus_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%0b req=%0b dat=%h ea=%0b eb=%0b addr=%h want all 0",
               o_busy, o_bus_req, o_instr_dat, o_err_align, o_err_bus, o_bus_addr);
    end
  endtask

  task automatic test_basic_read;
    bus_read("basic", 32'h0000_0100, 0, 0, 32'h2408_0005, 1'b0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    i_addr = 32'h0000_0300; i_rd_cmd = 1'b1;
    @(negedge clk);
    i_rd_cmd = 1'b0;
    #1;
    n_checks++;
    if (o_bus_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: got %0b want 1", o_bus_req); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_req: got %0b want 0", o_bus_req); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_instr_dat !== 32'h0 || o_bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: got busy=%0b dat=%h req=%0b want 0 0 0", o_busy, o_instr_dat, o_bus_req);
    end
  endtask

  task automatic test_slow_bus;
    bus_read("slow", 32'h0000_0140, 4, 2, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    i_addr = 32'h0000_0102; i_rd_cmd = 1'b1;
    #1;
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL misalign_busy: got %0b want 0", o_busy); end
    @(negedge clk);
    i_rd_cmd = 1'b0;
    #1;
    n_checks++;
    if (o_bus_req !== 1'b0 || o_err_align !== 1'b1 || o_err_bus !== 1'b0 || o_instr_dat !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign_result: got req=%0b ea=%0b eb=%0b dat=%h want 0 1 0 0",
               o_bus_req, o_err_align, o_err_bus, o_instr_dat);
    end
  endtask

  task automatic test_bus_error;
    bus_read("buserr", 32'h0000_0200, 0, 0, 32'hDEAD_BEEF, 1'b1);
    bus_read("after_err", 32'h0000_0204, 1, 1, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_stray;
    @(negedge clk);
    i_bus_ack = 1'b1; i_bus_rdy = 1'b1; i_bus_rdata = 32'h7777_7777; i_bus_err = 1'b1;
    @(negedge clk);
    i_bus_ack = 1'b0; i_bus_rdy = 1'b0; i_bus_err = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_bus_req !== 1'b0 || o_instr_dat !== 32'h0BAD_F00D || o_err_bus !== 1'b0) begin
      n_fail++;
      $display("FAIL stray: got busy=%0b req=%0b dat=%h eb=%0b want 0 0 0badf00d 0",
               o_busy, o_bus_req, o_instr_dat, o_err_bus);
    end
  endtask

  task automatic test_top_addr;
    bus_read("top_addr", 32'hFFFF_FFFC, 0, 0, 32'hCAFE_0001, 1'b0);
  endtask

  task automatic test_last_hit;
    bus_read("hit_fill", 32'h0000_0100, 0, 0, 32'h2408_0005, 1'b0);
`ifdef IFU_LAST_HIT_EN
    @(negedge clk);
    i_addr = 32'h0000_0100; i_rd_cmd = 1'b1;
    #1;
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL hit_busy: got %0b want 0", o_busy); end
    @(negedge clk);
    i_rd_cmd = 1'b0;
    #1;
    n_checks++;
    if (o_bus_req !== 1'b0 || o_instr_dat !== 32'h2408_0005) begin
      n_fail++;
      $display("FAIL hit_result: got req=%0b dat=%h want 0 24080005", o_bus_req, o_instr_dat);
    end
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    bus_read("after_flush", 32'h0000_0100, 0, 0, 32'h2408_0006, 1'b0);
`else
    bus_read("no_buffer", 32'h0000_0100, 0, 0, 32'h2408_0006, 1'b0);
`endif
  endtask

  initial begin
    test_reset;
    test_basic_read;
    test_reset_mid;
    test_slow_bus;
    test_misaligned;
    test_bus_error;
    test_stray;
    test_top_addr;
    test_last_hit;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
